// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Writer side of the instruction memory. Parses a framed byte
//            stream (sync 0xA5, 14-bit length, N word byte-pairs, checksum),
//            writes each assembled 14-bit word to consecutive addresses from 0
//            and keeps the CPU on hold until a checksum-verified image is in.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            in_valid_i        - in_data_i holds a byte this cycle
//            in_data_i         - stream byte
//            in_ready_o        - always 1, the loader never back-pressures
//            mem_we_o          - one-cycle instruction memory write strobe
//            mem_addr_o        - write address (word index)
//            mem_wdata_o       - write data (assembled word)
//            cpu_hold_o        - CPU held while high (every state but DONE)
//            done_o / error_o  - image accepted / frame rejected (sticky)
//            word_count_o      - words written in the current load
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 14,
    parameter int MAX_WORDS = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [13:0]       word_count_o
);

    localparam logic [7:0]  c_SYNC      = 8'hA5;
    localparam logic [14:0] c_MAX_WORDS = 15'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [13:0]         len_q, len_d;      // LEN_HI parked in [13:8] until LEN_LO arrives
    logic [5:0]          hi_q, hi_d;
    logic [7:0]          sum_q, sum_d;
    logic [13:0]         wc_q, wc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                hold_q, hold_d;

    logic [7:0]          w_sum;
    logic [13:0]         w_len;
    logic [13:0]         w_wc_inc;

    assign w_sum    = sum_q + in_data_i;
    assign w_len    = {len_q[13:8], in_data_i};
    assign w_wc_inc = wc_q + 14'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            wc_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            sum_q   <= sum_d;
            wc_q    <= wc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        sum_d   = sum_q;
        wc_d    = wc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
        hold_d  = hold_q;

        if (in_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (in_data_i == c_SYNC) begin
                        state_d = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    sum_d = w_sum;
                    if (in_data_i[7:6] != 2'b00) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        len_d   = {in_data_i[5:0], 8'h00};
                        state_d = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    sum_d = w_sum;
                    len_d = w_len;
                    if ((w_len == 14'd0) || ({1'b0, w_len} > c_MAX_WORDS)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    sum_d = w_sum;
                    if (in_data_i[7:6] != 2'b00) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        hi_d    = in_data_i[5:0];
                        state_d = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    // Write goes out the next cycle; the count before the
                    // increment is this word's address.
                    sum_d   = w_sum;
                    we_d    = 1'b1;
                    addr_d  = ADDR_W'(wc_q);
                    wdata_d = DATA_W'({hi_q, in_data_i});
                    wc_d    = w_wc_inc;
                    state_d = (w_wc_inc == len_q) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    sum_d = w_sum;
                    if (w_sum == 8'h00) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
                S_DONE, S_ERROR: begin
                    // Restart: a new sync re-arms the loader from a clean slate.
                    if (in_data_i == c_SYNC) begin
                        state_d = S_LEN_HI;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        hold_d  = 1'b1;
                        wc_d    = '0;
                        sum_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = 1'b1;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = wc_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader. A positional frame model
//            (byte index within the frame) predicts every output each cycle;
//            directed frames are pinned with literal expectations and then
//            randomized frames/gaps/resets are run against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        mem_we_o;
    logic [12:0] mem_addr_o;
    logic [13:0] mem_wdata_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;
    logic [13:0] word_count_o;

    prog_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic gap_en = 1'b0;

    // Captured memory image written by the DUT
    logic [13:0] tb_mem [0:8191];
    int          wr_cnt    = 0;
    int          last_addr = -1;
    always @(posedge clk) begin
        if (mem_we_o) begin
            tb_mem[mem_addr_o] <= mem_wdata_o;
            wr_cnt             <= wr_cnt + 1;
            last_addr          <= int'(mem_addr_o);
        end
    end

    // ---------------- behavioural model (frame position based) ----------
    logic        m_in_frame = 1'b0;
    int          m_pos = 0;
    int          m_n = 0;
    logic [5:0]  m_nhi = '0;
    logic [5:0]  m_hi = '0;
    logic [7:0]  m_sum = '0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    int          m_wc = 0;
    logic        m_we = 1'b0;
    int          m_addr = 0;
    logic [13:0] m_wdata = '0;
    logic        m_rst = 1'b0;

    task automatic model_step(input logic v, input logic [7:0] b, input logic r);
        m_we  = 1'b0;
        m_rst = r;
        if (r) begin
            m_in_frame = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_wc = 0; m_sum = '0; m_addr = 0; m_wdata = '0;
        end else if (v) begin
            if (!m_in_frame) begin
                if (b == 8'hA5) begin
                    m_in_frame = 1'b1; m_pos = 1; m_sum = '0; m_wc = 0;
                    m_done = 1'b0; m_err = 1'b0;
                end
            end else begin
                m_sum = m_sum + b;
                if (m_pos == 1) begin
                    if (b[7:6] != 2'b00) begin m_err = 1'b1; m_in_frame = 1'b0; end
                    else m_nhi = b[5:0];
                end else if (m_pos == 2) begin
                    m_n = int'(m_nhi) * 256 + int'(b);
                    if (m_n < 1 || m_n > 8192) begin m_err = 1'b1; m_in_frame = 1'b0; end
                end else if (m_pos <= 2 * m_n + 2) begin
                    if (m_pos % 2 == 1) begin
                        if (b[7:6] != 2'b00) begin m_err = 1'b1; m_in_frame = 1'b0; end
                        else m_hi = b[5:0];
                    end else begin
                        m_we = 1'b1; m_addr = (m_pos - 4) / 2;
                        m_wdata = {m_hi, b}; m_wc = m_wc + 1;
                    end
                end else begin
                    if (m_sum == 8'h00) m_done = 1'b1; else m_err = 1'b1;
                    m_in_frame = 1'b0;
                end
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("mem_we", mem_we_o, m_we);
        chk("done", done_o, m_done);
        chk("error", error_o, m_err);
        chk("cpu_hold", cpu_hold_o, !m_done);
        chk("word_count", word_count_o, m_wc);
        chk("in_ready", in_ready_o, 1);
        if (m_we || m_rst) begin
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_wdata", mem_wdata_o, m_wdata);
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare
    // at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] b, input logic r);
        in_valid_i = v;
        in_data_i  = b;
        reset      = r;
        model_step(v, b, r);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic send(input logic [7:0] b);
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) cycle(1'b0, 8'($urandom), 1'b0);
        end
        cycle(1'b1, b, 1'b0);
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
        in_valid_i = 1'b0;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_error"}, error_o, 0);
        chk({tag, "_hold"}, cpu_hold_o, 1);
        chk({tag, "_we"}, mem_we_o, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
        chk({tag, "_wc"}, word_count_o, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] s;
        int w0;
        int n;
        int mode;
        logic [13:0] w;
        logic [13:0] big_last;

        reset = 1'b1; in_valid_i = 1'b0; in_data_i = 8'h00;
        @(negedge clk);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        reset_values("rst");
        repeat (2) cycle(1'b0, 8'h00, 1'b0);

        // Good load
        w0 = wr_cnt;
        send_q('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h01, 8'hFF, 8'hB8});
        cycle(1'b0, 8'h00, 1'b0);
        chk("good_mem0", tb_mem[0], 14'h1234);
        chk("good_mem1", tb_mem[1], 14'h01FF);
        chk("good_writes", wr_cnt - w0, 2);
        chk("good_done", done_o, 1);
        chk("good_hold", cpu_hold_o, 0);
        chk("good_error", error_o, 0);
        chk("good_wc", word_count_o, 2);
        chk("model_done", m_done, 1);

        // Restart from DONE, then bad checksum
        send(8'hA5);
        chk("restart_done", done_o, 0);
        chk("restart_hold", cpu_hold_o, 1);
        chk("restart_wc", word_count_o, 0);
        w0 = wr_cnt;
        send_q('{8'h00, 8'h02, 8'h12, 8'h34, 8'h01, 8'hFF, 8'hB9});
        cycle(1'b0, 8'h00, 1'b0);
        chk("badchk_writes", wr_cnt - w0, 2);
        chk("badchk_error", error_o, 1);
        chk("badchk_done", done_o, 0);
        chk("badchk_hold", cpu_hold_o, 1);
        chk("model_err", m_err, 1);

        // Illegal HI byte
        w0 = wr_cnt;
        send_q('{8'hA5, 8'h00, 8'h01, 8'h40});
        chk("illhi_error", error_o, 1);
        send(8'h55);
        cycle(1'b0, 8'h00, 1'b0);
        chk("illhi_writes", wr_cnt - w0, 0);

        // Length bounds
        send_q('{8'hA5, 8'h00, 8'h00});
        chk("len0_error", error_o, 1);
        send_q('{8'hA5, 8'h20, 8'h01});
        chk("len8193_error", error_o, 1);

        // Gaps and garbage
        gap_en = 1'b1;
        send_q('{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h2A, 8'hD5});
        gap_en = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        chk("gap_mem0", tb_mem[0], 14'h002A);
        chk("gap_done", done_o, 1);

        // Reset mid-frame, then reload from address 0
        send_q('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
        chk("mid_we", mem_we_o, 1);
        cycle(1'b0, 8'h00, 1'b1);
        reset_values("midrst");
        send_q('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
        chk("reload_addr0", mem_addr_o, 0);
        chk("reload_data0", mem_wdata_o, 14'h1234);
        send_q('{8'h01, 8'hFF, 8'hB8});
        chk("reload_done", done_o, 1);

        // Maximum length image
        w0 = wr_cnt;
        q = '{8'hA5, 8'h20, 8'h00};
        s = 8'h20;
        big_last = '0;
        for (int i = 0; i < 8192; i++) begin
            w = 14'($urandom);
            q.push_back({2'b00, w[13:8]});
            q.push_back(w[7:0]);
            s = s + {2'b00, w[13:8]} + w[7:0];
            big_last = w;
        end
        q.push_back(8'h00 - s);
        send_q(q);
        cycle(1'b0, 8'h00, 1'b0);
        chk("big_writes", wr_cnt - w0, 8192);
        chk("big_last_addr", last_addr, 8191);
        chk("big_last_data", tb_mem[8191], big_last);
        chk("big_done", done_o, 1);
        chk("big_wc", word_count_o, 8192);

        // Randomized frames against the model
        for (int it = 0; it < 40; it++) begin
            gap_en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) send(8'h3C ^ 8'($urandom_range(0, 3)));
            n = $urandom_range(1, 6);
            mode = $urandom_range(0, 7);
            q = '{8'hA5, 8'(n >> 8), 8'(n)};
            if (mode == 3) begin q[1] = 8'h00; q[2] = 8'h00; end
            s = q[1] + q[2];
            for (int i = 0; i < n; i++) begin
                w = 14'($urandom);
                q.push_back({(mode == 1 && i == n - 1) ? 2'b01 : 2'b00, w[13:8]});
                q.push_back(w[7:0]);
                s = s + q[q.size() - 2] + q[q.size() - 1];
            end
            q.push_back((mode == 2) ? (8'h01 - s) : (8'h00 - s));
            send_q(q);
            cycle(1'b0, 8'h00, 1'b0);
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'h00, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream and assembles 14-bit instruction words from byte pairs.
- Writes the words into instruction memory at consecutive addresses starting at 0.
- Holds the CPU (PC counter, decoder) in hold until a complete, checksum-verified image has been loaded.
- Sits between an external byte source (UART receiver or test harness) and the instruction memory write port.

Parameters:
- ADDR_W, 13, instruction memory address width.
- DATA_W, 14, instruction word width.
- MAX_WORDS, 8192, largest accepted image length in words.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a byte this cycle.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- mem_we  output  1  one-cycle instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- cpu_hold  output  1  high means the CPU is held in reset/stall.
- done  output  1  image loaded and checksum OK.
- error  output  1  frame rejected.
- word_count  output  14  words written in the current load.

Behaviour:
- Frame format, in order:
  - sync byte 0xA5.
  - LEN_HI (bits[7:6] must be 0).
  - LEN_LO.
  - N word pairs, each {HI with bits[7:6] = 0, LO}. word = {HI[5:0], LO}.
  - CHK byte.
  - N = {LEN_HI[5:0], LEN_LO}. Valid range is 1..MAX_WORDS.
- Checksum rule: the 8-bit sum of LEN_HI, LEN_LO, all data bytes and CHK must equal 0x00 (mod 256). The sync byte is excluded.
- States:
  - IDLE: wait for sync. Non-0xA5 bytes are consumed and ignored.
  - LEN_HI: LEN_HI bits[7:6] ≠ 0 → ERROR.
  - LEN_LO: computed N = 0 or N > MAX_WORDS → ERROR.
  - DATA_HI: HI bits[7:6] ≠ 0 → ERROR.
  - DATA_LO.
  - CHECK: sum ≠ 0 → ERROR, else → DONE.
  - DONE.
  - ERROR.
- Transitions advance only on an accepted byte. DATA_LO returns to DATA_HI until N words are received, then goes to CHECK.
- in_ready = 1 in every state; the loader never back-pressures. Idle cycles (in_valid = 0) leave all state unchanged.
- Write timing:
  - The cycle after a LO byte is accepted: mem_we = 1 for exactly one cycle, mem_addr = word index, mem_wdata = assembled word.
  - word_count increments in that same cycle.
  - Addresses are 0..N-1 and never wrap, because N ≤ MAX_WORDS.
- Words are written as they arrive, so a checksum failure leaves the memory partially or fully written. error marks the image invalid.
- cpu_hold = 1 in every state except DONE. It deasserts the cycle after CHK is accepted, together with done rising.
- done and error are registered and mutually exclusive. Each holds until reset or a restart.
- Restart: in DONE or ERROR, an accepted 0xA5 byte does all of the following:
  - clears done and error;
  - sets cpu_hold = 1;
  - clears word_count and the checksum accumulator;
  - enters LEN_HI.
  - Other bytes in DONE or ERROR are ignored.
- A sync byte received inside a frame is treated as data; there is no resync mid-frame.
- Reset values: state IDLE, cpu_hold = 1, done = 0, error = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, word_count = 0, checksum = 0.
- Reset mid-frame aborts the load. A pending mem_we is dropped. The next frame writes from address 0.
- Arithmetic:
  - The checksum accumulator is 8 bits and wraps.
  - The length register is 14 bits and is compared against MAX_WORDS before data is accepted.

Test Plan:
- Good load: A5 00 02 12 34 01 FF B8 → writes [0] = 14'h1234, [1] = 14'h01FF, one mem_we per word; then done = 1, cpu_hold = 0, error = 0, word_count = 2.
- Bad checksum: same frame with B9 as CHK → both words still written; error = 1, done = 0, cpu_hold stays 1.
- Illegal HI byte: A5 00 01 40 → error = 1 immediately after 0x40; no mem_we; a following LO byte is ignored.
- Length bounds: A5 00 00 → error. A5 20 01 (N = 8193) → error. A5 20 00 with 8192 words and a correct CHK → last write at address 8191, done = 1.
- Gaps and garbage: 3C 00 A5 00 01 00 2A D5, with random in_valid = 0 cycles inserted → garbage ignored, [0] = 14'h002A written, done = 1.
- Reset and restart:
  - Assert reset after the first word of a 2-word frame → outputs return to reset values.
  - Resend the full good-load frame → writes restart at address 0.
  - From DONE, send A5 → done clears and cpu_hold = 1 on that cycle.
